fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage and IF/ID pipeline register of the 5-stage core, directly upstream of
//   decode and of the hazard unit. Generates the PC and drives a 1-cycle-latency synchronous
//   instruction memory. Holds IF/ID on the hazard unit's IF/ID halt and kills wrong-path fetches
//   on a branch/jump redirect. A one-entry skid buffer catches the in-flight response during a halt.
// PARAMETERS
//   RESET_ADDR  32'h0000_0000  PC loaded on reset; first fetch address
//   XLEN        32             PC / instruction width
// PORTS
//   i_clk            in   1     global clock
//   i_rst            in   1     global reset, synchronous, active-high
//   i_halt           in   1     IF/ID halt from hazard unit; hold PC and IF/ID register
//   i_redirect       in   1     branch/jump taken (from EX); flush and load new PC
//   i_redirect_pc    in   XLEN  redirect target
//   o_imem_ren       out  1     instruction memory read enable
//   o_imem_raddr     out  XLEN  instruction memory read address (= pc_q)
//   i_imem_rdata     in   XLEN  read data, valid the cycle after o_imem_ren was high
//   o_id_valid       out  1     IF/ID holds a valid instruction
//   o_id_pc          out  XLEN  PC of instruction in IF/ID
//   o_id_pc_plus4    out  XLEN  o_id_pc + 4
//   o_id_inst        out  XLEN  instruction word in IF/ID
// BEHAVIOUR
//   State: pc_q, req_valid_q/req_pc_q (in-flight request), skid_valid_q/skid_pc_q/skid_inst_q,
//   IF/ID regs. All state updates on posedge i_clk only.
//   Reset (i_rst=1 at edge): pc_q=RESET_ADDR; req_valid_q=0; skid_valid_q=0; o_id_valid=0;
//     o_id_pc=0; o_id_inst=0. o_imem_ren=0 combinationally while i_rst=1.
//   o_imem_raddr = pc_q; o_imem_ren = !i_rst && !i_halt && !i_redirect.
//   Priority per cycle: reset > redirect > halt > normal.
//   Redirect: pc_q<=i_redirect_pc; req_valid_q<=0; skid_valid_q<=0; o_id_valid<=0 (IF/ID data
//     don't-care). In-flight response arriving this cycle is discarded. Redirect wins over halt.
//   Halt (no redirect): pc_q, IF/ID held; no new request. If req_valid_q, capture
//     {req_pc_q, i_imem_rdata} into skid, skid_valid_q<=1; req_valid_q<=0. Consecutive halt
//     cycles hold skid unchanged.
//   Normal: IF/ID <= skid if skid_valid_q (skid_valid_q<=0); else {req_pc_q, i_imem_rdata}
//     with o_id_valid<=req_valid_q. Issue at pc_q: req_pc_q<=pc_q, req_valid_q<=1, pc_q<=pc_q+4.
//   Invariant: at most one in-flight request; skid and in-flight never both valid on halt entry.
//   Latency: instruction at address A reaches IF/ID 2 edges after A is presented with ren=1.
//   Steady-state throughput 1 instr/cycle; first valid IF/ID 2 cycles after reset release.
//   Arithmetic: PC +4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0); redirect_pc[1:0] used as given.
//   o_id_pc_plus4 combinational from o_id_pc, same modulo wrap.
//   Reset mid-halt or mid-redirect: reset wins; skid and in-flight discarded.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds outputs o_perf_stall_cnt[31:0] (+1 each cycle i_halt=1 and
//     i_redirect=0) and o_perf_flush_cnt[31:0] (+1 each cycle i_redirect=1); both saturate at
//     32'hFFFF_FFFF, clear on i_rst.
//   FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   Reset then 4 free cycles, imem[A]=A^32'hA5A5_0000 -> IF/ID shows pc 0,4,8 with matching
//     inst; o_id_valid first high 2 cycles after reset release.
//   Halt 3 cycles while pc 0x8 in flight -> IF/ID holds pc 0x4; ren=0; on release IF/ID=0x8
//     (from skid) then 0xC, no duplicate or dropped PC.
//   Redirect to 0x100 while pc 0x10 in flight -> next cycle o_id_valid=0; following IF/ID
//     sequence 0x100, 0x104.
//   Redirect and halt same cycle with skid valid -> skid dropped, IF/ID valid=0, resumes 0x100.
//   RESET_ADDR=32'hFFFF_FFF8, no stalls -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; o_id_pc_plus4
//     of 0xFFFF_FFFC is 0x0.
//   FETCH_PERF_EN: 5 halt cycles + 2 redirects -> stall_cnt=5, flush_cnt=2; i_rst clears both.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Optional FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          XLEN       = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_halt,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_ren,
    output logic [XLEN-1:0] o_imem_raddr,
    input  logic [XLEN-1:0] i_imem_rdata,
`ifdef FETCH_PERF_EN
    output logic [31:0]     o_perf_stall_cnt,
    output logic [31:0]     o_perf_flush_cnt,
`endif
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_pc_plus4,
    output logic [XLEN-1:0] o_id_inst
);

    logic [XLEN-1:0] pc_q;
    logic            req_valid_q;
    logic [XLEN-1:0] req_pc_q;
    logic            skid_valid_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] skid_inst_q;
    logic            id_valid_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_inst_q;

    assign o_imem_ren    = !i_rst && !i_halt && !i_redirect;
    assign o_imem_raddr  = pc_q;
    assign o_id_valid    = id_valid_q;
    assign o_id_pc       = id_pc_q;
    assign o_id_inst     = id_inst_q;
    assign o_id_pc_plus4 = id_pc_q + XLEN'(4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q         <= XLEN'(RESET_ADDR);
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_inst_q    <= '0;
        end else if (i_redirect) begin
            // wrong-path response returning this cycle is simply dropped
            pc_q         <= i_redirect_pc;
            req_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            id_valid_q   <= 1'b0;
        end else if (i_halt) begin
            if (req_valid_q) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= req_pc_q;
                skid_inst_q  <= i_imem_rdata;
                req_valid_q  <= 1'b0;
            end
        end else begin
            if (skid_valid_q) begin
                id_valid_q   <= 1'b1;
                id_pc_q      <= skid_pc_q;
                id_inst_q    <= skid_inst_q;
                skid_valid_q <= 1'b0;
            end else begin
                id_valid_q <= req_valid_q;
                id_pc_q    <= req_pc_q;
                id_inst_q  <= i_imem_rdata;
            end
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
            pc_q        <= pc_q + XLEN'(4);
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_stall_cnt <= '0;
            o_perf_flush_cnt <= '0;
        end else begin
            if (i_redirect && o_perf_flush_cnt != 32'hFFFF_FFFF)
                o_perf_flush_cnt <= o_perf_flush_cnt + 32'd1;
            if (i_halt && !i_redirect && o_perf_stall_cnt != 32'hFFFF_FFFF)
                o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: start-up, halt/skid, redirect, reset
// and PC wrap-around, with a 1-cycle synchronous instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;

    logic        w_ren;
    logic [31:0] w_raddr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_inst;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] w_stall_cnt;
    logic [31:0] w_flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_halt           (halt),
        .i_redirect       (redir),
        .i_redirect_pc    (rpc),
        .o_imem_ren       (ren),
        .o_imem_raddr     (raddr),
        .i_imem_rdata     (rdata),
`ifdef FETCH_PERF_EN
        .o_perf_stall_cnt (stall_cnt),
        .o_perf_flush_cnt (flush_cnt),
`endif
        .o_id_valid       (id_valid),
        .o_id_pc          (id_pc),
        .o_id_pc_plus4    (id_pc4),
        .o_id_inst        (id_inst)
    );

    fetch_stage #(.RESET_ADDR(32'hFFFF_FFF8)) dut_w (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_halt           (1'b0),
        .i_redirect       (1'b0),
        .i_redirect_pc    (32'h0),
        .o_imem_ren       (w_ren),
        .o_imem_raddr     (w_raddr),
        .i_imem_rdata     (w_rdata),
`ifdef FETCH_PERF_EN
        .o_perf_stall_cnt (w_stall_cnt),
        .o_perf_flush_cnt (w_flush_cnt),
`endif
        .o_id_valid       (w_valid),
        .o_id_pc          (w_pc),
        .o_id_pc_plus4    (w_pc4),
        .o_id_inst        (w_inst)
    );

    always @(posedge clk) begin
        if (ren)
            rdata <= raddr ^ 32'hA5A5_0000;
        if (w_ren)
            w_rdata <= w_raddr ^ 32'hA5A5_0000;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, pc ^ 32'hA5A5_0000);
    endtask

    initial begin
        rst   = 1'b1;
        halt  = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        tick();
        tick();
        chk("rst_ren", {31'b0, ren}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_raddr", raddr, 32'h0);
        chk("rst_wraddr", w_raddr, 32'hFFFF_FFF8);

        rst = 1'b0;
        #1;
        chk("ren_on", {31'b0, ren}, 32'd1);
        tick();
        chk("e1_valid", {31'b0, id_valid}, 32'd0);
        chk("e1_raddr", raddr, 32'h4);
        tick();
        chk_id("e2", 32'h0);
        chk("e2_pc4", id_pc4, 32'h4);
        chk("w2_pc", w_pc, 32'hFFFF_FFF8);
        chk("w2_inst", w_inst, 32'h5A5A_FFF8);
        tick();
        chk_id("e3", 32'h4);
        chk("w3_pc", w_pc, 32'hFFFF_FFFC);
        chk("w3_pc4", w_pc4, 32'h0);

        halt = 1'b1;
        #1;
        chk("halt_ren", {31'b0, ren}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_id("halt_hold", 32'h4);
            chk("halt_raddr", raddr, 32'hC);
            if (i == 0) begin
                chk("w4_pc", w_pc, 32'h0);
                chk("w4_inst", w_inst, 32'hA5A5_0000);
            end
        end
        halt = 1'b0;
        tick();
        chk_id("skid_out", 32'h8);
        tick();
        chk_id("post_skid", 32'hC);
`ifdef FETCH_PERF_EN
        chk("perf_stall3", stall_cnt, 32'd3);
        chk("perf_flush0", flush_cnt, 32'd0);
`endif

        redir = 1'b1;
        rpc   = 32'h100;
        #1;
        chk("redir_ren", {31'b0, ren}, 32'd0);
        tick();
        chk("redir_kill", {31'b0, id_valid}, 32'd0);
        redir = 1'b0;
        chk("redir_raddr", raddr, 32'h100);
        tick();
        chk("redir_bubble", {31'b0, id_valid}, 32'd0);
        tick();
        chk_id("redir_t0", 32'h100);
        tick();
        chk_id("redir_t1", 32'h104);

        halt = 1'b1;
        tick();
        chk_id("rh_hold", 32'h104);
        redir = 1'b1;
        rpc   = 32'h100;
        tick();
        chk("rh_kill", {31'b0, id_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_stall4", stall_cnt, 32'd4);
        chk("perf_flush2", flush_cnt, 32'd2);
`endif
        redir = 1'b0;
        halt  = 1'b0;
        tick();
        chk("rh_bubble", {31'b0, id_valid}, 32'd0);
        tick();
        chk_id("rh_t0", 32'h100);
        tick();
        chk_id("rh_t1", 32'h104);

        halt = 1'b1;
        tick();
        chk_id("rst_halt_hold", 32'h104);
`ifdef FETCH_PERF_EN
        chk("perf_stall5", stall_cnt, 32'd5);
        chk("perf_flush2b", flush_cnt, 32'd2);
`endif
        rst = 1'b1;
        #1;
        chk("rst2_ren", {31'b0, ren}, 32'd0);
        tick();
        chk("rst2_valid", {31'b0, id_valid}, 32'd0);
        chk("rst2_pc", id_pc, 32'h0);
        chk("rst2_raddr", raddr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_stall_clr", stall_cnt, 32'd0);
        chk("perf_flush_clr", flush_cnt, 32'd0);
`endif
        rst  = 1'b0;
        halt = 1'b0;
        tick();
        chk("rst2_bubble", {31'b0, id_valid}, 32'd0);
        tick();
        chk_id("rst2_t0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
